// File: rtl/store_unit_pkg.sv
// Shared types and constants for the store unit: store ops, access masks/sizes, FSM states.
package store_unit_pkg;

    localparam int STORE_OP_WIDTH = 2;

    typedef enum logic [STORE_OP_WIDTH-1:0] {
        STORE_OP_SB   = 2'd0,
        STORE_OP_SH   = 2'd1,
        STORE_OP_SW   = 2'd2,
        STORE_OP_NONE = 2'd3
    } store_op_e;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [2:0] SIZE_B = 3'd1;
    localparam logic [2:0] SIZE_H = 3'd2;
    localparam logic [2:0] SIZE_W = 3'd4;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_BEAT1 = 3'd2,
        S_BEAT2 = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_e;

endpackage

// File: rtl/store_decoder.sv
// Combinational store decode: funct3/AMO and byte offset to op, byte mask and
// alignment/word-crossing flags.
module store_decoder
    import store_unit_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       amo_data_store,
    input  logic [1:0] off,
    output store_op_e  op,
    output logic [3:0] mask,
    output logic       misaligned,
    output logic       crossing,
    output logic       illegal
);

    logic [2:0] size;
    logic [3:0] end_byte;

    always_comb begin
        op   = STORE_OP_NONE;
        mask = '0;
        size = '0;
        if (amo_data_store) begin
            op = STORE_OP_SW;
        end else begin
            case (funct3)
                F3_SB:   op = STORE_OP_SB;
                F3_SH:   op = STORE_OP_SH;
                F3_SW:   op = STORE_OP_SW;
                default: op = STORE_OP_NONE;
            endcase
        end
        case (op)
            STORE_OP_SB: begin mask = MASK_B; size = SIZE_B; end
            STORE_OP_SH: begin mask = MASK_H; size = SIZE_H; end
            STORE_OP_SW: begin mask = MASK_W; size = SIZE_W; end
            default:     begin mask = '0;     size = '0;     end
        endcase
    end

    assign illegal    = (op == STORE_OP_NONE);
    assign misaligned = ((op == STORE_OP_SH) && off[0]) || ((op == STORE_OP_SW) && (|off));
    // Last byte touched lies past the word when off + size exceeds 4.
    assign end_byte   = {2'b00, off} + {1'b0, size};
    assign crossing   = (end_byte > 4'd4);

endmodule

// File: rtl/store_unit.sv
// Store unit: latches a store request, decodes it, and issues one or two
// word-aligned bus write beats over valid/ready, or a one-cycle fault pulse.
module store_unit
    import store_unit_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b0,
    parameter int ADDR_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            funct3,
    input  logic                  amo_data_store,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    output logic                  done,
    output logic                  store_fault,
    output logic                  fault_cause,
    output logic [ADDR_WIDTH-1:0] fault_addr
);

    state_e                state, state_nxt;
    logic [2:0]            funct3_q;
    logic                  amo_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  cause_q;

    store_op_e             op;
    logic [3:0]            mask;
    logic                  misaligned, crossing, illegal;

    logic                  accept;
    logic [1:0]            off;
    logic [2:0]            rem;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           wdata1, wdata2;
    logic [3:0]            strb1, strb2;

    store_decoder u_dec (
        .funct3         (funct3_q),
        .amo_data_store (amo_q),
        .off            (off),
        .op             (op),
        .mask           (mask),
        .misaligned     (misaligned),
        .crossing       (crossing),
        .illegal        (illegal)
    );

    assign accept = req_valid && req_ready;
    assign off    = addr_q[1:0];
    assign rem    = 3'd4 - {1'b0, off};
    assign base   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign wdata1 = wdata_q << {off, 3'b000};
    assign strb1  = mask << off;
    // Second beat carries the bytes that spilled past the first word.
    assign wdata2 = wdata_q >> {rem, 3'b000};
    assign strb2  = mask >> rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cause_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_CHECK) begin
                cause_q <= (op == STORE_OP_NONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            funct3_q <= funct3;
            amo_q    <= amo_data_store;
            addr_q   <= addr;
            wdata_q  <= wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_CHECK;
            S_CHECK: begin
                if (illegal) begin
                    state_nxt = S_FAULT;
                end else if (misaligned && (!SPLIT_MISALIGNED || amo_q)) begin
                    state_nxt = S_FAULT;
                end else begin
                    state_nxt = S_BEAT1;
                end
            end
            S_BEAT1: if (mem_ready) state_nxt = crossing ? S_BEAT2 : S_DONE;
            S_BEAT2: if (mem_ready) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            S_FAULT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign req_ready   = (state == S_IDLE) && !reset;
    assign mem_valid   = (state == S_BEAT1) || (state == S_BEAT2);
    assign mem_addr    = (state == S_BEAT2) ? (base + ADDR_WIDTH'(4)) : base;
    assign mem_wdata   = (state == S_BEAT2) ? wdata2 : wdata1;
    assign mem_wstrb   = (state == S_BEAT1) ? strb1 : ((state == S_BEAT2) ? strb2 : 4'b0000);
    assign done        = (state == S_DONE);
    assign store_fault = (state == S_FAULT);
    assign fault_cause = cause_q;
    assign fault_addr  = addr_q;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: two instances (split off / split on), directed table,
// reset-abandon sequence and randomized stores against a byte-level model.
module tb_store_unit;

    typedef struct {
        logic        fault;
        logic        cause;
        int          nbeats;
        logic [31:0] a0, d0, a1, d1;
        logic [3:0]  s0, s1;
    } exp_t;

    typedef struct {
        int          u;
        logic [2:0]  f3;
        logic        amo;
        logic [31:0] addr, wdata;
        int          delay;
        exp_t        e;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       funct3;
    logic             amo;
    logic [31:0]      addr, wdata;
    logic [1:0]       rv, mr;
    logic [1:0]       rr, mv, dn, sf, fc;
    logic [1:0][31:0] ma, md, fa;
    logic [1:0][3:0]  ms;

    int checks = 0;
    int failures = 0;

    int          o_done, o_fault, o_nbeats, o_first_c, o_term_c, o_stab;
    bit          o_timeout;
    logic        o_cause;
    logic [31:0] o_faddr;
    logic [31:0] o_a [2];
    logic [31:0] o_d [2];
    logic [3:0]  o_s [2];

    always #5 clk = ~clk;

    store_unit #(.SPLIT_MISALIGNED(1'b0), .ADDR_WIDTH(32)) dut0 (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rr[0]),
        .funct3(funct3), .amo_data_store(amo), .addr(addr), .wdata(wdata),
        .mem_valid(mv[0]), .mem_ready(mr[0]), .mem_addr(ma[0]), .mem_wdata(md[0]),
        .mem_wstrb(ms[0]), .done(dn[0]), .store_fault(sf[0]), .fault_cause(fc[0]),
        .fault_addr(fa[0])
    );

    store_unit #(.SPLIT_MISALIGNED(1'b1), .ADDR_WIDTH(32)) dut1 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rr[1]),
        .funct3(funct3), .amo_data_store(amo), .addr(addr), .wdata(wdata),
        .mem_valid(mv[1]), .mem_ready(mr[1]), .mem_addr(ma[1]), .mem_wdata(md[1]),
        .mem_wstrb(ms[1]), .done(dn[1]), .store_fault(sf[1]), .fault_cause(fc[1]),
        .fault_addr(fa[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Byte-level reference: each byte of the access goes to its own word/lane.
    function automatic exp_t model(input int u, input logic [2:0] f3, input logic am,
                                   input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int          size, lane;
        logic [31:0] w0, ba, wa;
        e.fault = 0; e.cause = 0; e.nbeats = 0;
        e.a0 = 0; e.d0 = 0; e.a1 = 0; e.d1 = 0; e.s0 = 0; e.s1 = 0;
        size = am ? 4 : (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        if (size == 0) begin
            e.fault = 1; e.cause = 1;
            return e;
        end
        if ((int'(a[1:0]) % size) != 0 && (u == 0 || am)) begin
            e.fault = 1; e.cause = 0;
            return e;
        end
        w0 = a & ~32'd3;
        e.a0 = w0;
        e.a1 = w0 + 32'd4;
        for (int i = 0; i < size; i++) begin
            ba   = a + 32'(i);
            wa   = ba & ~32'd3;
            lane = int'(ba[1:0]);
            if (wa == w0) begin
                e.d0[8*lane +: 8] = d[8*i +: 8];
                e.s0[lane] = 1'b1;
                if (e.nbeats < 1) e.nbeats = 1;
            end else begin
                e.d1[8*lane +: 8] = d[8*i +: 8];
                e.s1[lane] = 1'b1;
                e.nbeats = 2;
            end
        end
        return e;
    endfunction

    function automatic vec_t mkv(input int u, input logic [2:0] f3, input logic am,
                                 input logic [31:0] a, input logic [31:0] d, input int dly,
                                 input logic flt, input logic cs, input int nb,
                                 input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                                 input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
        vec_t v;
        v.u = u; v.f3 = f3; v.amo = am; v.addr = a; v.wdata = d; v.delay = dly;
        v.e.fault = flt; v.e.cause = cs; v.e.nbeats = nb;
        v.e.a0 = a0; v.e.d0 = d0; v.e.s0 = s0; v.e.a1 = a1; v.e.d1 = d1; v.e.s1 = s1;
        return v;
    endfunction

    // Called at a negedge; returns at a negedge with the unit idle again.
    task automatic run_store(input int u, input logic [2:0] f3, input logic am,
                             input logic [31:0] a, input logic [31:0] d, input int dly);
        int          c, wcnt, wt;
        bit          in_beat, term;
        logic [31:0] ca, cd;
        logic [3:0]  cs;
        o_done = 0; o_fault = 0; o_nbeats = 0; o_first_c = -1; o_term_c = -1; o_stab = 0;
        o_timeout = 0; o_cause = 1'bx; o_faddr = 'x;
        o_a[0] = 0; o_a[1] = 0; o_d[0] = 0; o_d[1] = 0; o_s[0] = 0; o_s[1] = 0;
        in_beat = 0; term = 0; wcnt = 0; ca = 0; cd = 0; cs = 0;
        wt = 0;
        while (!rr[u] && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        if (!rr[u]) o_timeout = 1;
        funct3 = f3; amo = am; addr = a; wdata = d;
        rv[u] = 1'b1;
        @(negedge clk);
        rv[u] = 1'b0;
        c = 1;
        while (c < 60) begin
            mr[u] = 1'b0;
            if (mv[u]) begin
                if (!in_beat) begin
                    in_beat = 1; ca = ma[u]; cd = md[u]; cs = ms[u]; wcnt = 0;
                    if (o_nbeats == 0) o_first_c = c;
                end else if (ma[u] !== ca || md[u] !== cd || ms[u] !== cs) begin
                    o_stab++;
                end
                if (wcnt == dly) begin
                    mr[u] = 1'b1;
                    if (o_nbeats < 2) begin
                        o_a[o_nbeats] = ca; o_d[o_nbeats] = cd; o_s[o_nbeats] = cs;
                    end
                    o_nbeats++;
                    in_beat = 0;
                end else begin
                    wcnt++;
                end
            end
            if (dn[u]) begin
                o_done++;
                if (!term) o_term_c = c;
                term = 1;
            end
            if (sf[u]) begin
                o_fault++; o_cause = fc[u]; o_faddr = fa[u];
                if (!term) o_term_c = c;
                term = 1;
            end
            if (term && c >= o_term_c + 2) break;
            @(negedge clk);
            c++;
        end
        mr[u] = 1'b0;
        if (!term) o_timeout = 1;
    endtask

    task automatic check_obs(input string tag, input exp_t e, input logic [31:0] a, input int dly);
        chk({tag, ".timeout"}, 32'(o_timeout), 32'd0);
        if (e.fault) begin
            chk({tag, ".fault_cnt"}, o_fault, 1);
            chk({tag, ".done_cnt"}, o_done, 0);
            chk({tag, ".cause"}, 32'(o_cause), 32'(e.cause));
            chk({tag, ".fault_addr"}, o_faddr, a);
            chk({tag, ".no_valid"}, o_first_c, -1);
            chk({tag, ".fault_lat"}, o_term_c, 2);
        end else begin
            chk({tag, ".done_cnt"}, o_done, 1);
            chk({tag, ".fault_cnt"}, o_fault, 0);
            chk({tag, ".nbeats"}, o_nbeats, e.nbeats);
            chk({tag, ".valid_lat"}, o_first_c, 2);
            chk({tag, ".done_lat"}, o_term_c, 2 + e.nbeats * (dly + 1));
            chk({tag, ".stable"}, o_stab, 0);
            chk({tag, ".b0_addr"}, o_a[0], e.a0);
            chk({tag, ".b0_data"}, o_d[0], e.d0);
            chk({tag, ".b0_strb"}, 32'(o_s[0]), 32'(e.s0));
            if (e.nbeats == 2) begin
                chk({tag, ".b1_addr"}, o_a[1], e.a1);
                chk({tag, ".b1_data"}, o_d[1], e.d1);
                chk({tag, ".b1_strb"}, 32'(o_s[1]), 32'(e.s1));
            end
        end
    endtask

    initial begin
        vec_t        tbl [12];
        exp_t        e;
        int          u, dly, cnt;
        logic [2:0]  f3;
        logic        am;
        logic [31:0] a, d;

        tbl[0]  = mkv(0, 3'b000, 0, 32'h0000_1003, 32'h0000_00AB, 0, 0, 0, 1,
                      32'h0000_1000, 32'hAB00_0000, 4'b1000, 0, 0, 0);
        tbl[1]  = mkv(0, 3'b001, 0, 32'h0000_2002, 32'h0000_1234, 3, 0, 0, 1,
                      32'h0000_2000, 32'h1234_0000, 4'b1100, 0, 0, 0);
        tbl[2]  = mkv(0, 3'b010, 0, 32'h0000_3001, 32'h1122_3344, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mkv(1, 3'b010, 0, 32'h0000_3001, 32'h1122_3344, 0, 0, 0, 2,
                      32'h0000_3000, 32'h2233_4400, 4'b1110, 32'h0000_3004, 32'h0000_0011, 4'b0001);
        tbl[4]  = mkv(1, 3'b010, 1, 32'h0000_4002, 32'hCAFE_F00D, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mkv(1, 3'b011, 0, 32'h0000_4000, 32'h0000_0000, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mkv(0, 3'b011, 0, 32'h0000_4004, 32'h0000_0000, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mkv(1, 3'b001, 0, 32'h0000_5001, 32'h0000_BEEF, 0, 0, 0, 1,
                      32'h0000_5000, 32'h00BE_EF00, 4'b0110, 0, 0, 0);
        tbl[8]  = mkv(1, 3'b001, 0, 32'h0000_5003, 32'h0000_BEEF, 1, 0, 0, 2,
                      32'h0000_5000, 32'hEF00_0000, 4'b1000, 32'h0000_5004, 32'h0000_00BE, 4'b0001);
        tbl[9]  = mkv(1, 3'b010, 0, 32'hFFFF_FFFE, 32'hAABB_CCDD, 0, 0, 0, 2,
                      32'hFFFF_FFFC, 32'hCCDD_0000, 4'b1100, 32'h0000_0000, 32'h0000_AABB, 4'b0011);
        tbl[10] = mkv(0, 3'b010, 0, 32'h0000_6000, 32'hDEAD_BEEF, 2, 0, 0, 1,
                      32'h0000_6000, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0);
        tbl[11] = mkv(0, 3'b000, 0, 32'h0000_7001, 32'h0000_005A, 0, 0, 0, 1,
                      32'h0000_7000, 32'h0000_5A00, 4'b0010, 0, 0, 0);

        reset = 1'b1; rv = '0; mr = '0; funct3 = '0; amo = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset.mem_valid%0d", i), 32'(mv[i]), 0);
            chk($sformatf("reset.done%0d", i), 32'(dn[i]), 0);
            chk($sformatf("reset.fault%0d", i), 32'(sf[i]), 0);
            chk($sformatf("reset.wstrb%0d", i), 32'(ms[i]), 0);
            chk($sformatf("reset.req_ready%0d", i), 32'(rr[i]), 0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset.req_ready0", 32'(rr[0]), 1);
        chk("post_reset.req_ready1", 32'(rr[1]), 1);

        for (int i = 0; i < 12; i++) begin
            run_store(tbl[i].u, tbl[i].f3, tbl[i].amo, tbl[i].addr, tbl[i].wdata, tbl[i].delay);
            check_obs($sformatf("vec%0d", i), tbl[i].e, tbl[i].addr, tbl[i].delay);
        end

        // Reset while the second beat of a split SW is still waiting for ready.
        funct3 = 3'b010; amo = 1'b0; addr = 32'h0000_8001; wdata = 32'h1122_3344;
        rv[1] = 1'b1;
        @(negedge clk);
        rv[1] = 1'b0;
        @(negedge clk);
        chk("rst_seq.beat1_valid", 32'(mv[1]), 1);
        mr[1] = 1'b1;
        @(negedge clk);
        mr[1] = 1'b0;
        chk("rst_seq.beat2_valid", 32'(mv[1]), 1);
        chk("rst_seq.beat2_addr", ma[1], 32'h0000_8004);
        @(negedge clk);
        chk("rst_seq.beat2_held", 32'(mv[1]), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_seq.valid_dropped", 32'(mv[1]), 0);
        chk("rst_seq.no_done", 32'(dn[1]), 0);
        chk("rst_seq.ready_in_reset", 32'(rr[1]), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_seq.ready_after", 32'(rr[1]), 1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (dn[1] || mv[1] || sf[1]) cnt++;
            @(negedge clk);
        end
        chk("rst_seq.quiet_after", cnt, 0);

        for (int n = 0; n < 200; n++) begin
            u  = n % 2;
            f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            am = ($urandom_range(0, 7) == 0);
            a  = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            d  = $urandom;
            if (!am && f3 == 3'd0) d = d & 32'h0000_00FF;
            else if (!am && f3 == 3'd1) d = d & 32'h0000_FFFF;
            dly = $urandom_range(0, 2);
            e = model(u, f3, am, a, d);
            run_store(u, f3, am, a, d, dly);
            check_obs($sformatf("rnd%0d", n), e, a, dly);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
